can_rx: RTL
===========

# can_rx

Receive stage of the CAN controller. Consumes the serial bus bit stream that `can_tx` produces (and any other node drives), recovers bit timing from the single system clock, removes stuff bits, checks CRC and frame form, and drives the ACK slot. It delivers one decoded standard (11-bit ID) data frame per `data_valid` pulse, with address and data formats matching what `can_tx` accepts.

## Interface
- `CLKS_PER_BIT`, 800: `clk` cycles per bus bit (200 MHz / 250 kbit/s).
- `SAMPLE_POINT`, 400: phase count at which the bit is sampled; must be in 1..`CLKS_PER_BIT`-2.
- `clk`  in  1  system clock; only clock in the block.
- `rst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  bus level; 0 = dominant, 1 = recessive.
- `tx_ack`  out  1  ACK drive; 0 = dominant during ACK slot, otherwise 1.
- `address`  out  11  received identifier.
- `data`  out  32  received payload; first byte in [31:24]; unreceived bytes are 0.
- `dlc`  out  4  received data length code.
- `rtr`  out  1  received RTR bit.
- `data_valid`  out  1  one-cycle pulse: frame complete and good.
- `crc_err`, `stuff_err`, `form_err`  out  1 each  one-cycle error pulses.
- `busy`  out  1  high from SOF detection until return to idle.

## Operation
- `rx` passes through a 2-FF synchronizer; all logic uses the synchronized value.
- Bit timing: phase counter 0..`CLKS_PER_BIT`-1. In WAIT_SOF, a 1→0 edge hard-syncs the counter to 0. Inside a frame, every 1→0 edge also resets the counter to 0 (resync). The bit is sampled when the counter equals `SAMPLE_POINT`.
- States and transitions:
  - INTEGRATE → WAIT_SOF after 11 consecutive recessive samples (entered after reset and after ERROR).
  - WAIT_SOF → ARB on a dominant sample.
  - ARB: 11 ID bits MSB first, then RTR.
  - CTRL: IDE, r0, DLC[3:0]. IDE=1 → form_err. DLC>4 → form_err.
  - DATA: 8·DLC bits, MSB first. Skipped when DLC=0 or RTR=1.
  - CRC: 15 bits → CRC_DELIM → ACK → ACK_DELIM → EOF (7 bits) → WAIT_SOF.
- Destuffing applies from SOF through the last CRC bit:
  - After 5 equal samples, the next sample is a stuff bit and is discarded.
  - If that stuff bit equals the previous 5 → stuff_err.
- CRC: polynomial 15'h4599, initial value 0, computed over destuffed bits SOF..last data bit. Received CRC ≠ computed CRC → crc_err, raised at the CRC_DELIM sample.
- Recessive required at CRC delimiter, ACK delimiter and all EOF bits; a dominant sample there → form_err. The ACK slot value is ignored.
- `tx_ack` = 0 for the whole ACK bit period (from the CRC_DELIM sample point +`CLKS_PER_BIT`/2 ... practically from start to end of the ACK bit) only if the CRC matched; otherwise `tx_ack` stays 1.
- On any error: pulse the flag, go to ERROR, suppress `data_valid`, leave outputs unchanged. ERROR → INTEGRATE.
- `address`/`data`/`dlc`/`rtr` update only together with `data_valid`, and hold until the next good frame.

## Timing
- Reset values: `tx_ack`=1, `address`=0, `data`=0, `dlc`=0, `rtr`=0, all pulses 0, `busy`=0, state INTEGRATE.
- Sample latency: the bus edge reaches the synchronized signal after 2 clks. Sample is taken `SAMPLE_POINT` clks after the synchronized edge.
- `data_valid` asserts 1 clk after the sample of EOF bit 7, for exactly 1 clk.
- Error pulses assert 1 clk after the offending sample.
- `tx_ack` falls at the ACK bit's boundary (counter wrap after CRC_DELIM) and rises at the next wrap.
- Reset mid-frame: immediate return to reset values. No partial frame is reported, and 11 recessive bits are required before the next SOF is accepted.
- Simultaneous stuff and CRC/form conditions at one sample: report stuff_err only.

## Structure
- `can_pkg`:
  - state enum
  - `CAN_CRC_POLY` = 15'h4599
  - field lengths: ID 11, DLC 4, CRC 15, EOF 7, INTEGRATE 11
  - stuff limit 5
  - `can_tx` shares this package.
- Sub-module `can_crc15`: serial CRC with `clr`, `en`, `bit_in` and a 15-bit `crc` output; reusable by `can_tx`.

## Test plan
- Loopback from `can_tx`, address 11'h028, data 32'hAAAAAAAA → `data_valid` once; `address`=028, `data`=AAAAAAAA, `dlc`=4, `rtr`=0; `tx_ack`=0 during the ACK bit only.
- Same frame with one CRC bit inverted → `crc_err` pulse; no `data_valid`; `tx_ack` stays 1; outputs unchanged.
- Six consecutive dominant bits inside the ID field → `stuff_err`. The next good frame, after 11 recessive bits, is received correctly.
- DLC=2, payload 8'h12, 8'h34 → `data`=32'h12340000, `dlc`=2.
- IDE=1 frame → `form_err`. DLC=5 frame → `form_err`. Dominant sample in EOF bit 3 → `form_err`. No `data_valid` in any of these cases.
- `rst` low mid-DATA → all outputs return to reset values. A SOF sent after only 5 recessive bits is ignored, while one sent after 11 recessive bits is received.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN constants, FSM encodings and the serial CRC-15 step.
// Used by can_rx and can_tx.
package can_pkg;

  localparam logic [14:0] CAN_CRC_POLY = 15'h4599;

  localparam int ID_LEN        = 11;
  localparam int DLC_LEN       = 4;
  localparam int CRC_LEN       = 15;
  localparam int EOF_LEN       = 7;
  localparam int INTEGRATE_LEN = 11;
  localparam int STUFF_LIMIT   = 5;

  typedef logic [3:0] can_state_t;

  localparam can_state_t ST_INTEGRATE = 4'd0;
  localparam can_state_t ST_WAIT_SOF  = 4'd1;
  localparam can_state_t ST_ARB       = 4'd2;
  localparam can_state_t ST_CTRL      = 4'd3;
  localparam can_state_t ST_DATA      = 4'd4;
  localparam can_state_t ST_CRC       = 4'd5;
  localparam can_state_t ST_CRC_DELIM = 4'd6;
  localparam can_state_t ST_ACK       = 4'd7;
  localparam can_state_t ST_ACK_DELIM = 4'd8;
  localparam can_state_t ST_EOF       = 4'd9;
  localparam can_state_t ST_ERROR     = 4'd10;

  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[14];
    crc15_step = {crc[13:0], 1'b0} ^ (fb ? CAN_CRC_POLY : 15'h0000);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 accumulator; clr has priority over en.
module can_crc15
  import can_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [14:0] crc
);

  logic [14:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc15_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_rx.sv
// CAN receive stage: bit timing recovery, destuffing, CRC/form checks, ACK drive
// and delivery of standard data frames.
module can_rx
  import can_pkg::*;
#(
  parameter int CLKS_PER_BIT = 800,
  parameter int SAMPLE_POINT = 400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        tx_ack,
  output logic [10:0] address,
  output logic [31:0] data,
  output logic [3:0]  dlc,
  output logic        rtr,
  output logic        data_valid,
  output logic        crc_err,
  output logic        stuff_err,
  output logic        form_err,
  output logic        busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_POINT);
  localparam logic [5:0] RTR_POS    = 6'(ID_LEN);
  localparam logic [5:0] CTRL_LAST  = 6'(DLC_LEN + 1);
  localparam logic [5:0] CRC_LAST   = 6'(CRC_LEN - 1);
  localparam logic [5:0] EOF_LAST   = 6'(EOF_LEN - 1);
  localparam logic [3:0] INTEG_LAST = 4'(INTEGRATE_LEN - 1);
  localparam logic [2:0] STUFF_MAX  = 3'(STUFF_LIMIT);

  logic rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  can_state_t state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  integ_cnt_q, integ_cnt_d;
  logic [2:0]  same_cnt_q, same_cnt_d;
  logic        last_bit_q, last_bit_d;
  logic [10:0] id_rx_q, id_rx_d;
  logic        rtr_rx_q, rtr_rx_d;
  logic [3:0]  dlc_rx_q, dlc_rx_d;
  logic [31:0] data_rx_q, data_rx_d;
  logic [14:0] crc_rx_q, crc_rx_d;
  logic        tx_ack_q, tx_ack_d;
  logic [10:0] address_q, address_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  dlc_q, dlc_d;
  logic        rtr_q, rtr_d;
  logic        data_valid_q, data_valid_d;
  logic        crc_err_q, crc_err_d, stuff_err_q, stuff_err_d, form_err_q, form_err_d;

  logic        rx_bit, fall, sample, wrap, stuff_zone, crc_clr, crc_en;
  logic [3:0]  dlc_new;
  logic [14:0] crc_calc;

  assign rx_bit  = rx_sync_q;
  assign fall    = rx_prev_q & ~rx_sync_q;
  assign sample  = (cnt_q == CNT_SAMPLE);
  assign wrap    = (cnt_q == CNT_LAST);
  assign dlc_new = {dlc_rx_q[2:0], rx_bit};
  // A stuff bit may still follow the last CRC bit, so the CRC delimiter slot
  // is treated as stuffed when a run of five is pending.
  assign stuff_zone = (state_q == ST_ARB) || (state_q == ST_CTRL) || (state_q == ST_DATA) ||
                      (state_q == ST_CRC) ||
                      ((state_q == ST_CRC_DELIM) && (same_cnt_q == STUFF_MAX));

  can_crc15 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (rx_bit),
    .crc    (crc_calc)
  );

  always_comb begin
    rx_meta_d    = rx;
    rx_sync_d    = rx_meta_q;
    rx_prev_d    = rx_sync_q;
    cnt_d        = (fall || wrap) ? '0 : cnt_q + 1'b1;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    integ_cnt_d  = integ_cnt_q;
    same_cnt_d   = same_cnt_q;
    last_bit_d   = last_bit_q;
    id_rx_d      = id_rx_q;
    rtr_rx_d     = rtr_rx_q;
    dlc_rx_d     = dlc_rx_q;
    data_rx_d    = data_rx_q;
    crc_rx_d     = crc_rx_q;
    tx_ack_d     = tx_ack_q;
    address_d    = address_q;
    data_d       = data_q;
    dlc_d        = dlc_q;
    rtr_d        = rtr_q;
    data_valid_d = 1'b0;
    crc_err_d    = 1'b0;
    stuff_err_d  = 1'b0;
    form_err_d   = 1'b0;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;

    // ACK drive spans exactly one bit: from the wrap that opens the ACK slot to the next wrap.
    if (wrap && !tx_ack_q) tx_ack_d = 1'b1;
    if (wrap && (state_q == ST_ACK)) tx_ack_d = 1'b0;

    if (sample) begin
      if (stuff_zone && (same_cnt_q == STUFF_MAX)) begin
        if (rx_bit == last_bit_q) begin
          stuff_err_d = 1'b1;
          state_d     = ST_ERROR;
        end else begin
          last_bit_d = rx_bit;
          same_cnt_d = 3'd1;
        end
      end else begin
        if (stuff_zone) begin
          last_bit_d = rx_bit;
          same_cnt_d = (rx_bit == last_bit_q) ? same_cnt_q + 1'b1 : 3'd1;
        end
        crc_en = (state_q == ST_ARB) || (state_q == ST_CTRL) || (state_q == ST_DATA);
        case (state_q)
          ST_INTEGRATE: begin
            if (!rx_bit) integ_cnt_d = '0;
            else if (integ_cnt_q == INTEG_LAST) state_d = ST_WAIT_SOF;
            else integ_cnt_d = integ_cnt_q + 1'b1;
          end
          ST_WAIT_SOF: begin
            if (!rx_bit) begin
              state_d    = ST_ARB;
              bit_cnt_d  = '0;
              same_cnt_d = 3'd1;
              last_bit_d = 1'b0;
              data_rx_d  = '0;
              crc_clr    = 1'b1;
            end
          end
          ST_ARB: begin
            if (bit_cnt_q == RTR_POS) begin
              rtr_rx_d  = rx_bit;
              state_d   = ST_CTRL;
              bit_cnt_d = '0;
            end else begin
              id_rx_d   = {id_rx_q[9:0], rx_bit};
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          ST_CTRL: begin
            if ((bit_cnt_q == 6'd0) && rx_bit) begin
              form_err_d = 1'b1;
              state_d    = ST_ERROR;
            end else if (bit_cnt_q == CTRL_LAST) begin
              dlc_rx_d  = dlc_new;
              bit_cnt_d = '0;
              if (dlc_new > 4'd4) begin
                form_err_d = 1'b1;
                state_d    = ST_ERROR;
              end else if (rtr_rx_q || (dlc_new == 4'd0)) begin
                state_d = ST_CRC;
              end else begin
                state_d = ST_DATA;
              end
            end else begin
              if (bit_cnt_q >= 6'd2) dlc_rx_d = dlc_new;
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          ST_DATA: begin
            data_rx_d[~bit_cnt_q[4:0]] = rx_bit;
            if (bit_cnt_q == 6'({dlc_rx_q, 3'b000} - 7'd1)) begin
              state_d   = ST_CRC;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          ST_CRC: begin
            crc_rx_d = {crc_rx_q[13:0], rx_bit};
            if (bit_cnt_q == CRC_LAST) state_d = ST_CRC_DELIM;
            else bit_cnt_d = bit_cnt_q + 1'b1;
          end
          ST_CRC_DELIM: begin
            if (crc_rx_q != crc_calc) begin
              crc_err_d = 1'b1;
              state_d   = ST_ERROR;
            end else if (!rx_bit) begin
              form_err_d = 1'b1;
              state_d    = ST_ERROR;
            end else begin
              state_d = ST_ACK;
            end
          end
          ST_ACK: state_d = ST_ACK_DELIM;
          ST_ACK_DELIM: begin
            if (!rx_bit) begin
              form_err_d = 1'b1;
              state_d    = ST_ERROR;
            end else begin
              state_d   = ST_EOF;
              bit_cnt_d = '0;
            end
          end
          ST_EOF: begin
            if (!rx_bit) begin
              form_err_d = 1'b1;
              state_d    = ST_ERROR;
            end else if (bit_cnt_q == EOF_LAST) begin
              data_valid_d = 1'b1;
              address_d    = id_rx_q;
              data_d       = data_rx_q;
              dlc_d        = dlc_rx_q;
              rtr_d        = rtr_rx_q;
              state_d      = ST_WAIT_SOF;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    if (state_q == ST_ERROR) begin
      state_d     = ST_INTEGRATE;
      integ_cnt_d = '0;
      tx_ack_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      cnt_q        <= '0;
      state_q      <= ST_INTEGRATE;
      bit_cnt_q    <= '0;
      integ_cnt_q  <= '0;
      same_cnt_q   <= '0;
      last_bit_q   <= 1'b1;
      id_rx_q      <= '0;
      rtr_rx_q     <= 1'b0;
      dlc_rx_q     <= '0;
      data_rx_q    <= '0;
      crc_rx_q     <= '0;
      tx_ack_q     <= 1'b1;
      address_q    <= '0;
      data_q       <= '0;
      dlc_q        <= '0;
      rtr_q        <= 1'b0;
      data_valid_q <= 1'b0;
      crc_err_q    <= 1'b0;
      stuff_err_q  <= 1'b0;
      form_err_q   <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      integ_cnt_q  <= integ_cnt_d;
      same_cnt_q   <= same_cnt_d;
      last_bit_q   <= last_bit_d;
      id_rx_q      <= id_rx_d;
      rtr_rx_q     <= rtr_rx_d;
      dlc_rx_q     <= dlc_rx_d;
      data_rx_q    <= data_rx_d;
      crc_rx_q     <= crc_rx_d;
      tx_ack_q     <= tx_ack_d;
      address_q    <= address_d;
      data_q       <= data_d;
      dlc_q        <= dlc_d;
      rtr_q        <= rtr_d;
      data_valid_q <= data_valid_d;
      crc_err_q    <= crc_err_d;
      stuff_err_q  <= stuff_err_d;
      form_err_q   <= form_err_d;
    end
  end

  assign tx_ack     = tx_ack_q;
  assign address    = address_q;
  assign data       = data_q;
  assign dlc        = dlc_q;
  assign rtr        = rtr_q;
  assign data_valid = data_valid_q;
  assign crc_err    = crc_err_q;
  assign stuff_err  = stuff_err_q;
  assign form_err   = form_err_q;
  assign busy       = (state_q != ST_INTEGRATE) && (state_q != ST_WAIT_SOF);

endmodule
